// File: rtl/mac_result_accumulator_pkg.sv
// Shared types and helpers for the MAC result accumulator.
// Holds default widths, the reduce-mode code, FSM states and saturation.
package mac_result_accumulator_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_IN_W  = 32;
  localparam int DEF_ACC_W = 40;
  localparam int DEF_OUT_W = 32;

  localparam logic [1:0] MODE_REDUCE = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_OUT_W-1:0] val;
    logic                 sat;
  } sat_t;

  // Clamp when the bits above the output sign bit disagree with it.
  function automatic sat_t saturate(
    input logic [DEF_ACC_W-1:0] a
  );
    sat_t r;
    logic [DEF_ACC_W-DEF_OUT_W:0] hi;
    hi = a[DEF_ACC_W-1:DEF_OUT_W-1];
    if ((&hi) || !(|hi)) begin
      r.val = a[DEF_OUT_W-1:0];
      r.sat = 1'b0;
    end else if (a[DEF_ACC_W-1]) begin
      r.val = {1'b1, {(DEF_OUT_W-1){1'b0}}};
      r.sat = 1'b1;
    end else begin
      r.val = {1'b0, {(DEF_OUT_W-1){1'b1}}};
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_result_accumulator_fifo.sv
// Two-entry first-in first-out result buffer, head always in r_e0.
// Unused slots are kept at zero so an empty FIFO presents zero data.
module result_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] r_e0;
  logic [W-1:0] r_e1;
  logic [1:0]   r_cnt;
  logic         w_pop;
  logic         w_push;

  assign empty_o = (r_cnt == 2'd0);
  assign full_o  = (r_cnt == 2'd2);
  assign dout_o  = r_e0;

  // A pop frees the slot a same-cycle push fills, even when full.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      unique case (1'b1)
        (w_push && w_pop): begin
          if (r_cnt == 2'd1) begin
            r_e0 <= din_i;
          end else begin
            r_e0 <= r_e1;
            r_e1 <= din_i;
          end
        end
        (w_push && !w_pop): begin
          if (r_cnt == 2'd0) r_e0 <= din_i;
          else               r_e1 <= din_i;
          r_cnt <= r_cnt + 2'd1;
        end
        (!w_push && w_pop): begin
          r_e0  <= r_e1;
          r_e1  <= '0;
          r_cnt <= r_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mac_result_accumulator.sv
// Accumulates 4-lane partial-sum beats into dot-product groups and
// queues saturated group results for the writeback/requant stage.
module mac_result_accumulator
  import mac_result_accumulator_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic [1:0]             mode_i,
  input  logic                   in_valid_i,
  input  logic                   in_last_i,
  input  logic [LANES*IN_W-1:0]  in_data_i,
  output logic                   busy_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*OUT_W-1:0] out_data_o,
  output logic [LANES-1:0]       out_sat_o,
  output logic                   overflow_o
);

  localparam int FW = LANES*OUT_W + LANES;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_busy;

  logic [1:0] r_mode;
  logic       w_first;
  logic       w_reduce;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       r_ovf;

  logic [ACC_W-1:0] r_acc     [LANES];
  logic [ACC_W-1:0] w_acc_nxt [LANES];
  sat_t             w_lsat    [LANES];
  logic [ACC_W-1:0] w_sum;
  sat_t             w_rsat;

  logic [LANES*OUT_W-1:0] w_pdata;
  logic [LANES-1:0]       w_psat;
  logic [FW-1:0]          w_dout;

  assign w_first  = (r_state == ST_IDLE);
  // Mode is only taken from the first beat of a group.
  assign w_reduce = w_first ? (mode_i == MODE_REDUCE)
                            : (r_mode == MODE_REDUCE);
  assign w_push   = in_valid_i & in_last_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state <= ST_IDLE;
      r_mode  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (in_valid_i && w_first) r_mode <= mode_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:
        if (in_valid_i && !in_last_i) w_state_nxt = ST_ACCUM;
      ST_ACCUM:
        if (in_valid_i && in_last_i)  w_state_nxt = ST_IDLE;
      default:
        w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == ST_ACCUM) | ~w_empty;
  end

  assign busy_o = w_busy;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IN_W-1:0]  w_in;
    logic [ACC_W-1:0] w_sext;

    assign w_in   = in_data_i[k*IN_W +: IN_W];
    assign w_sext = {{(ACC_W-IN_W){w_in[IN_W-1]}}, w_in};
    assign w_acc_nxt[k] = w_first ? w_sext : r_acc[k] + w_sext;
    assign w_lsat[k]    = saturate(w_acc_nxt[k]);

    always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) r_acc[k] <= '0;
      else if (in_valid_i)  r_acc[k] <= w_acc_nxt[k];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < LANES; k++) w_sum = w_sum + w_acc_nxt[k];
  end

  assign w_rsat = saturate(w_sum);

  always_comb begin
    w_pdata = '0;
    w_psat  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!w_reduce) begin
        w_pdata[k*OUT_W +: OUT_W] = w_lsat[k].val;
        w_psat[k]                 = w_lsat[k].sat;
      end
    end
    if (w_reduce) begin
      w_pdata[OUT_W-1:0] = w_rsat.val;
      w_psat[0]          = w_rsat.sat;
    end
  end

  assign w_pop = out_ready_i & ~w_empty;

  result_fifo2 #(
    .W(FW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   ({w_psat, w_pdata}),
    .dout_o  (w_dout),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i)                 r_ovf <= 1'b0;
    else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
  end

  assign out_valid_o = ~w_empty;
  assign out_data_o  = w_dout[LANES*OUT_W-1:0];
  assign out_sat_o   = w_dout[FW-1:LANES*OUT_W];
  assign overflow_o  = r_ovf;

endmodule
